// File: rtl/spartan_split.sv
// One-master-to-two-slave Spartan bus splitter: address-routed request path
// and packet-atomic round-robin response merge, each through a 2-entry skid.

module spartan_split_skid #(
  parameter int W = 66
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_vld,
  output logic         in_rdy,
  output logic [W-1:0] out_data,
  output logic         out_vld,
  input  logic         out_rdy
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         en_q;
  logic         push, pop;

  // en_q keeps the input ready low for as long as reset is held
  assign in_rdy   = en_q && (count_q != 2'd2);
  assign out_vld  = (count_q != 2'd0);
  assign out_data = head_q;
  assign push     = in_vld && in_rdy;
  assign pop      = out_vld && out_rdy;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_data;
        else                 tail_d = in_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      en_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      en_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

endmodule

module spartan_split #(
  parameter int BWIDTH  = 64,
  parameter int SEL_BIT = 31
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [BWIDTH+1:0] SpMBUS,
  input  logic              SpMVLD,
  output logic              SpMRDY,
  output logic [BWIDTH+1:0] SpSBUS,
  output logic              SpSVLD,
  input  logic              SpSRDY,
  output logic [BWIDTH+1:0] SpMBUS_0,
  output logic [BWIDTH+1:0] SpMBUS_1,
  output logic              SpMVLD_0,
  output logic              SpMVLD_1,
  input  logic              SpMRDY_0,
  input  logic              SpMRDY_1,
  input  logic [BWIDTH+1:0] SpSBUS_0,
  input  logic [BWIDTH+1:0] SpSBUS_1,
  input  logic              SpSVLD_0,
  input  logic              SpSVLD_1,
  output logic              SpSRDY_0,
  output logic              SpSRDY_1
);

  localparam int FW = BWIDTH + 2;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

  logic [FW-1:0] req_head;
  logic          req_vld;
  logic          req_out_rdy;
  logic          req_target;
  logic          req_is_hdr;
  logic          route_q, route_d;

  logic [FW-1:0] rsp_in_bus;
  logic          rsp_in_vld;
  logic          rsp_in_rdy;
  logic          grant;
  arb_state_e    arb_state_q, arb_state_d;
  logic          lock_grant_q, lock_grant_d;
  logic          prio_q, prio_d;

  spartan_split_skid #(.W(FW)) u_req_skid (
    .clk      (CLK),
    .rst_n    (RST),
    .in_data  (SpMBUS),
    .in_vld   (SpMVLD),
    .in_rdy   (SpMRDY),
    .out_data (req_head),
    .out_vld  (req_vld),
    .out_rdy  (req_out_rdy)
  );

  // Data flits follow the slave chosen by the most recent header to leave
  always_comb begin
    req_is_hdr  = !req_head[FW-1];
    req_target  = req_is_hdr ? req_head[SEL_BIT] : route_q;
    req_out_rdy = req_target ? SpMRDY_1 : SpMRDY_0;
    route_d     = route_q;
    if (req_vld && req_out_rdy && req_is_hdr) route_d = req_head[SEL_BIT];
  end

  assign SpMBUS_0 = req_head;
  assign SpMBUS_1 = req_head;
  assign SpMVLD_0 = req_vld && !req_target;
  assign SpMVLD_1 = req_vld && req_target;

  // Grant is held for the whole packet once its first non-last flit moves
  always_comb begin
    arb_state_d  = arb_state_q;
    lock_grant_d = lock_grant_q;
    prio_d       = prio_q;
    grant        = prio_q;
    if (arb_state_q == ARB_LOCK)      grant = lock_grant_q;
    else if (SpSVLD_0 && !SpSVLD_1)   grant = 1'b0;
    else if (SpSVLD_1 && !SpSVLD_0)   grant = 1'b1;
    rsp_in_bus = grant ? SpSBUS_1 : SpSBUS_0;
    rsp_in_vld = grant ? SpSVLD_1 : SpSVLD_0;
    if (rsp_in_vld && rsp_in_rdy) begin
      if (rsp_in_bus[FW-1] == rsp_in_bus[FW-2]) begin
        arb_state_d = ARB_IDLE;
        prio_d      = !grant;
      end else begin
        arb_state_d  = ARB_LOCK;
        lock_grant_d = grant;
      end
    end
  end

  assign SpSRDY_0 = rsp_in_rdy && !grant;
  assign SpSRDY_1 = rsp_in_rdy && grant;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      route_q      <= 1'b0;
      arb_state_q  <= ARB_IDLE;
      lock_grant_q <= 1'b0;
      prio_q       <= 1'b0;
    end else begin
      route_q      <= route_d;
      arb_state_q  <= arb_state_d;
      lock_grant_q <= lock_grant_d;
      prio_q       <= prio_d;
    end
  end

  spartan_split_skid #(.W(FW)) u_rsp_skid (
    .clk      (CLK),
    .rst_n    (RST),
    .in_data  (rsp_in_bus),
    .in_vld   (rsp_in_vld),
    .in_rdy   (rsp_in_rdy),
    .out_data (SpSBUS),
    .out_vld  (SpSVLD),
    .out_rdy  (SpSRDY)
  );

endmodule

// File: tb/tb_spartan_split.sv
// Directed bench for spartan_split: routing, back-pressure, response
// arbitration, packet locking and mid-packet reset.

module tb_spartan_split;

  localparam int BW = 64;
  localparam int FW = BW + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] SpMBUS, SpSBUS, SpMBUS_0, SpMBUS_1, SpSBUS_0, SpSBUS_1;
  logic          SpMVLD, SpMRDY, SpSVLD, SpSRDY;
  logic          SpMVLD_0, SpMVLD_1, SpMRDY_0, SpMRDY_1;
  logic          SpSVLD_0, SpSVLD_1, SpSRDY_0, SpSRDY_1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [FW-1:0] q0[$], q1[$], qm[$];
  int            t1[$];
  logic [FW-1:0] pk[4];
  logic [FW-1:0] exp_q[$];

  spartan_split #(.BWIDTH(BW), .SEL_BIT(31)) dut (
    .CLK      (clk),
    .RST      (rst_n),
    .SpMBUS   (SpMBUS),
    .SpMVLD   (SpMVLD),
    .SpMRDY   (SpMRDY),
    .SpSBUS   (SpSBUS),
    .SpSVLD   (SpSVLD),
    .SpSRDY   (SpSRDY),
    .SpMBUS_0 (SpMBUS_0),
    .SpMBUS_1 (SpMBUS_1),
    .SpMVLD_0 (SpMVLD_0),
    .SpMVLD_1 (SpMVLD_1),
    .SpMRDY_0 (SpMRDY_0),
    .SpMRDY_1 (SpMRDY_1),
    .SpSBUS_0 (SpSBUS_0),
    .SpSBUS_1 (SpSBUS_1),
    .SpSVLD_0 (SpSVLD_0),
    .SpSVLD_1 (SpSVLD_1),
    .SpSRDY_0 (SpSRDY_0),
    .SpSRDY_1 (SpSRDY_1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every handshake that the coming rising edge will complete
  always @(negedge clk) begin
    if (rst_n) begin
      if (SpMVLD_0 && SpMRDY_0) q0.push_back(SpMBUS_0);
      if (SpMVLD_1 && SpMRDY_1) begin
        q1.push_back(SpMBUS_1);
        t1.push_back(cyc);
      end
      if (SpSVLD && SpSRDY) qm.push_back(SpSBUS);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [FW-1:0] mk(input logic [1:0] ty, input logic sel, input logic [15:0] id);
    logic [BW-1:0] p;
    p     = 64'h5A5A_0000_0000_0000 | {48'd0, id};
    p[31] = sel;
    return {ty, p};
  endfunction

  task automatic checkOutput(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [FW-1:0] f);
    logic acc;
    acc    = 1'b0;
    SpMBUS = f;
    SpMVLD = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = SpMRDY;
      tick();
    end
    if (!acc) checkOutput("req_accept_timeout", FW'(0), FW'(1));
    SpMVLD = 1'b0;
  endtask

  task automatic sendRsp0(input logic [FW-1:0] f);
    logic acc;
    acc      = 1'b0;
    SpSBUS_0 = f;
    SpSVLD_0 = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = SpSRDY_0;
      tick();
    end
    if (!acc) checkOutput("rsp0_accept_timeout", FW'(0), FW'(1));
    SpSVLD_0 = 1'b0;
  endtask

  task automatic sendRsp1(input logic [FW-1:0] f);
    logic acc;
    acc      = 1'b0;
    SpSBUS_1 = f;
    SpSVLD_1 = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = SpSRDY_1;
      tick();
    end
    if (!acc) checkOutput("rsp1_accept_timeout", FW'(0), FW'(1));
    SpSVLD_1 = 1'b0;
  endtask

  task automatic waitQueue(input int which, input int n);
    for (int k = 0; k < 60; k++) begin
      if ((which == 0 && q0.size() >= n) || (which == 1 && q1.size() >= n) ||
          (which == 2 && qm.size() >= n)) break;
      tick();
    end
  endtask

  task automatic clearQueues();
    q0.delete();
    q1.delete();
    qm.delete();
    t1.delete();
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    SpMVLD   = 1'b0;
    SpSVLD_0 = 1'b0;
    SpSVLD_1 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clearQueues();
  endtask

  initial begin
    rst_n    = 1'b0;
    SpMBUS   = '0;
    SpMVLD   = 1'b0;
    SpSRDY   = 1'b1;
    SpMRDY_0 = 1'b1;
    SpMRDY_1 = 1'b1;
    SpSBUS_0 = '0;
    SpSBUS_1 = '0;
    SpSVLD_0 = 1'b0;
    SpSVLD_1 = 1'b0;

    // reset values
    tick();
    tick();
    checkOutput("rst_mrdy",  FW'(SpMRDY),   FW'(0));
    checkOutput("rst_mvld0", FW'(SpMVLD_0), FW'(0));
    checkOutput("rst_mvld1", FW'(SpMVLD_1), FW'(0));
    checkOutput("rst_svld",  FW'(SpSVLD),   FW'(0));
    checkOutput("rst_srdy0", FW'(SpSRDY_0), FW'(0));
    checkOutput("rst_srdy1", FW'(SpSRDY_1), FW'(0));
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_mrdy",  FW'(SpMRDY),   FW'(1));
    checkOutput("post_rst_srdy0", FW'(SpSRDY_0), FW'(1));
    checkOutput("post_rst_srdy1", FW'(SpSRDY_1), FW'(0));

    // single-flit header to slave 0, one cycle latency
    pk[0]  = mk(2'b00, 1'b0, 16'h0001);
    SpMBUS = pk[0];
    SpMVLD = 1'b1;
    tick();
    SpMVLD = 1'b0;
    checkOutput("sf_vld0", FW'(SpMVLD_0), FW'(1));
    checkOutput("sf_bus0", SpMBUS_0, pk[0]);
    checkOutput("sf_vld1", FW'(SpMVLD_1), FW'(0));
    tick();
    checkOutput("sf_vld0_drained", FW'(SpMVLD_0), FW'(0));
    clearQueues();

    // four-flit packet to slave 1, data flits carry bit31 = 0
    pk[0] = mk(2'b01, 1'b1, 16'h0010);
    pk[1] = mk(2'b10, 1'b0, 16'h0011);
    pk[2] = mk(2'b10, 1'b0, 16'h0012);
    pk[3] = mk(2'b11, 1'b0, 16'h0013);
    for (int i = 0; i < 4; i++) applyStimulus(pk[i]);
    waitQueue(1, 4);
    repeat (3) tick();
    checkOutput("mf_count", FW'(q1.size()), FW'(4));
    for (int i = 0; i < 4; i++)
      if (i < q1.size()) checkOutput($sformatf("mf_flit%0d", i), q1[i], pk[i]);
    checkOutput("mf_s0_quiet", FW'(q0.size()), FW'(0));
    if (t1.size() >= 4) checkOutput("mf_rate", FW'(t1[3] - t1[0]), FW'(3));
    clearQueues();

    // slave 1 stalled for 5 cycles during a 4-flit packet
    pk[0] = mk(2'b01, 1'b1, 16'h0020);
    pk[1] = mk(2'b10, 1'b0, 16'h0021);
    pk[2] = mk(2'b10, 1'b0, 16'h0022);
    pk[3] = mk(2'b11, 1'b0, 16'h0023);
    SpMRDY_1 = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(pk[i]);
      end
      begin
        tick();
        checkOutput("bp_rdy_one_buffered", FW'(SpMRDY), FW'(1));
        tick();
        tick();
        checkOutput("bp_rdy_low", FW'(SpMRDY), FW'(0));
        checkOutput("bp_vld1_held", FW'(SpMVLD_1), FW'(1));
        tick();
        tick();
        SpMRDY_1 = 1'b1;
      end
    join
    waitQueue(1, 4);
    repeat (3) tick();
    checkOutput("bp_count", FW'(q1.size()), FW'(4));
    for (int i = 0; i < 4; i++)
      if (i < q1.size()) checkOutput($sformatf("bp_flit%0d", i), q1[i], pk[i]);
    if (t1.size() >= 4) checkOutput("bp_rate", FW'(t1[3] - t1[0]), FW'(3));

    // response arbitration: A/B together, lone C, then D/E together
    doReset();
    fork
      begin
        sendRsp0(mk(2'b01, 1'b0, 16'h00A0));
        sendRsp0(mk(2'b10, 1'b0, 16'h00A1));
        sendRsp0(mk(2'b11, 1'b0, 16'h00A2));
      end
      begin
        sendRsp1(mk(2'b01, 1'b0, 16'h00B0));
        sendRsp1(mk(2'b10, 1'b0, 16'h00B1));
        sendRsp1(mk(2'b11, 1'b0, 16'h00B2));
      end
    join
    sendRsp0(mk(2'b00, 1'b0, 16'h00C0));
    fork
      begin
        sendRsp0(mk(2'b01, 1'b0, 16'h00D0));
        sendRsp0(mk(2'b10, 1'b0, 16'h00D1));
        sendRsp0(mk(2'b11, 1'b0, 16'h00D2));
      end
      begin
        sendRsp1(mk(2'b01, 1'b0, 16'h00E0));
        sendRsp1(mk(2'b10, 1'b0, 16'h00E1));
        sendRsp1(mk(2'b11, 1'b0, 16'h00E2));
      end
    join
    waitQueue(2, 13);
    exp_q.delete();
    exp_q.push_back(mk(2'b01, 1'b0, 16'h00A0));
    exp_q.push_back(mk(2'b10, 1'b0, 16'h00A1));
    exp_q.push_back(mk(2'b11, 1'b0, 16'h00A2));
    exp_q.push_back(mk(2'b01, 1'b0, 16'h00B0));
    exp_q.push_back(mk(2'b10, 1'b0, 16'h00B1));
    exp_q.push_back(mk(2'b11, 1'b0, 16'h00B2));
    exp_q.push_back(mk(2'b00, 1'b0, 16'h00C0));
    exp_q.push_back(mk(2'b01, 1'b0, 16'h00E0));
    exp_q.push_back(mk(2'b10, 1'b0, 16'h00E1));
    exp_q.push_back(mk(2'b11, 1'b0, 16'h00E2));
    exp_q.push_back(mk(2'b01, 1'b0, 16'h00D0));
    exp_q.push_back(mk(2'b10, 1'b0, 16'h00D1));
    exp_q.push_back(mk(2'b11, 1'b0, 16'h00D2));
    checkOutput("arb_count", FW'(qm.size()), FW'(13));
    for (int i = 0; i < 13; i++)
      if (i < qm.size()) checkOutput($sformatf("arb_flit%0d", i), qm[i], exp_q[i]);
    qm.delete();

    // slave 1 streams singles while slave 0's packet has a 2-cycle gap
    fork
      begin
        for (int i = 0; i < 6; i++) sendRsp1(mk(2'b00, 1'b0, 16'(16'h00C0 + i)));
      end
      begin
        sendRsp0(mk(2'b01, 1'b0, 16'h0070));
        sendRsp0(mk(2'b10, 1'b0, 16'h0071));
        tick();
        tick();
        sendRsp0(mk(2'b10, 1'b0, 16'h0072));
        sendRsp0(mk(2'b11, 1'b0, 16'h0073));
      end
    join
    waitQueue(2, 10);
    exp_q.delete();
    exp_q.push_back(mk(2'b00, 1'b0, 16'h00C0));
    exp_q.push_back(mk(2'b01, 1'b0, 16'h0070));
    exp_q.push_back(mk(2'b10, 1'b0, 16'h0071));
    exp_q.push_back(mk(2'b10, 1'b0, 16'h0072));
    exp_q.push_back(mk(2'b11, 1'b0, 16'h0073));
    for (int i = 1; i < 6; i++) exp_q.push_back(mk(2'b00, 1'b0, 16'(16'h00C0 + i)));
    checkOutput("lock_count", FW'(qm.size()), FW'(10));
    for (int i = 0; i < 10; i++)
      if (i < qm.size()) checkOutput($sformatf("lock_flit%0d", i), qm[i], exp_q[i]);

    // reset in the middle of a request packet and a locked response packet
    applyStimulus(mk(2'b00, 1'b1, 16'h00D0));
    tick();
    SpMRDY_1 = 1'b0;
    applyStimulus(mk(2'b01, 1'b1, 16'h00D1));
    applyStimulus(mk(2'b10, 1'b0, 16'h00D2));
    SpSRDY = 1'b0;
    sendRsp1(mk(2'b01, 1'b0, 16'h00E0));
    checkOutput("pre_rst_svld",  FW'(SpSVLD),   FW'(1));
    checkOutput("pre_rst_mvld1", FW'(SpMVLD_1), FW'(1));
    rst_n = 1'b0;
    tick();
    checkOutput("mid_rst_mvld0", FW'(SpMVLD_0), FW'(0));
    checkOutput("mid_rst_mvld1", FW'(SpMVLD_1), FW'(0));
    checkOutput("mid_rst_svld",  FW'(SpSVLD),   FW'(0));
    checkOutput("mid_rst_mrdy",  FW'(SpMRDY),   FW'(0));
    rst_n    = 1'b1;
    SpSRDY   = 1'b1;
    SpMRDY_1 = 1'b1;
    tick();
    clearQueues();
    checkOutput("after_rst_mvld1", FW'(SpMVLD_1), FW'(0));
    checkOutput("after_rst_svld",  FW'(SpSVLD),   FW'(0));

    // stray data flit follows the cleared route to slave 0
    pk[0] = mk(2'b11, 1'b1, 16'h00D3);
    applyStimulus(pk[0]);
    waitQueue(0, 1);
    checkOutput("route_clr_count0", FW'(q0.size()), FW'(1));
    if (q0.size() > 0) checkOutput("route_clr_flit", q0[0], pk[0]);
    checkOutput("route_clr_count1", FW'(q1.size()), FW'(0));
    pk[1] = mk(2'b00, 1'b1, 16'h00D4);
    applyStimulus(pk[1]);
    waitQueue(1, 1);
    checkOutput("post_rst_hdr_count1", FW'(q1.size()), FW'(1));
    if (q1.size() > 0) checkOutput("post_rst_hdr_flit", q1[0], pk[1]);

    // response lock must be gone, slave 0 gets through
    pk[2] = mk(2'b00, 1'b0, 16'h00F0);
    sendRsp0(pk[2]);
    waitQueue(2, 1);
    repeat (3) tick();
    checkOutput("post_rst_rsp_count", FW'(qm.size()), FW'(1));
    if (qm.size() > 0) checkOutput("post_rst_rsp_flit", qm[0], pk[2]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
